matmul_seq: RTL

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_seq_if.sv | 31 +++
 rtl/matmul_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/matmul_seq_if.sv
// Handshake bundle for matmul_seq: X stream in, A ROM port, Y results out, status.
interface matmul_seq_if #(
   parameter int unsigned A_W = 14,
   parameter int unsigned X_W = 8
);
   localparam int unsigned Y_W = A_W + X_W + 2;

   logic           start;
   logic           aload_done;
   logic           x_valid;
   logic [X_W-1:0] x_data;
   logic           x_ready;
   logic [4:0]     rom_addr;
   logic [A_W-1:0] A_input;
   logic           y_valid;
   logic           y_ready;
   logic [Y_W-1:0] y_data;
   logic [2:0]     y_index;
   logic           busy;
   logic           done;

   modport master (
      output start, aload_done, x_valid, x_data, A_input, y_ready,
      input  x_ready, rom_addr, y_valid, y_data, y_index, busy, done
   );

   modport slave (
      input  start, aload_done, x_valid, x_data, A_input, y_ready,
      output x_ready, rom_addr, y_valid, y_data, y_index, busy, done
   );
endinterface

// File: rtl/matmul_seq.sv
// Sequential 8x4 matrix by 4-vector product; A streamed column-major from a
// synchronous ROM, one row result emitted per handshake.
module matmul_seq #(
   parameter int unsigned A_W = 14,
   parameter int unsigned X_W = 8
) (
   input logic          clk,
   input logic          rst,
   matmul_seq_if.slave  bus
);
   localparam int unsigned P_W = A_W + X_W;
   localparam int unsigned Y_W = A_W + X_W + 2;

   typedef enum logic [2:0] {IDLE, LOAD_X, ISSUE, DRAIN, OUT} state_t;

   state_t         state;
   logic [1:0]     x_cnt;
   logic [1:0]     j_cnt;
   logic [2:0]     row;
   logic [X_W-1:0] x_reg [4];
   logic [Y_W-1:0] acc;
   logic           mac_vld;
   logic [1:0]     mac_j;

   logic           x_ready_q;
   logic [4:0]     rom_addr_q;
   logic           y_valid_q;
   logic [Y_W-1:0] y_data_q;
   logic [2:0]     y_index_q;
   logic           busy_q;
   logic           done_q;

   logic [P_W-1:0] prod_c;
   logic [Y_W-1:0] acc_sum_c;

   // ROM data lags its address by one cycle; mac_j tracks which X it pairs with.
   assign prod_c    = P_W'(bus.A_input) * P_W'(x_reg[mac_j]);
   assign acc_sum_c = acc + Y_W'(prod_c);

   assign bus.x_ready  = x_ready_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.y_valid  = y_valid_q;
   assign bus.y_data   = y_data_q;
   assign bus.y_index  = y_index_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         x_cnt      <= '0;
         j_cnt      <= '0;
         row        <= '0;
         for (int k = 0; k < 4; k++) x_reg[k] <= '0;
         acc        <= '0;
         mac_vld    <= 1'b0;
         mac_j      <= '0;
         x_ready_q  <= 1'b0;
         rom_addr_q <= '0;
         y_valid_q  <= 1'b0;
         y_data_q   <= '0;
         y_index_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         mac_vld <= 1'b0;
         mac_j   <= j_cnt;
         if (mac_vld) acc <= acc_sum_c;

         case (state)
            IDLE: begin
               if (bus.start && bus.aload_done) begin
                  state     <= LOAD_X;
                  x_ready_q <= 1'b1;
                  busy_q    <= 1'b1;
                  x_cnt     <= '0;
               end
            end
            LOAD_X: begin
               if (bus.x_valid && x_ready_q) begin
                  x_reg[x_cnt] <= bus.x_data;
                  x_cnt        <= x_cnt + 2'd1;
                  if (x_cnt == 2'd3) begin
                     state      <= ISSUE;
                     x_ready_q  <= 1'b0;
                     row        <= '0;
                     j_cnt      <= '0;
                     rom_addr_q <= '0;
                     acc        <= '0;
                  end
               end
            end
            // Address {j,i} equals j*8+i: column-major A layout.
            ISSUE: begin
               mac_vld <= 1'b1;
               j_cnt   <= j_cnt + 2'd1;
               if (j_cnt == 2'd3) begin
                  state      <= DRAIN;
                  rom_addr_q <= '0;
               end else begin
                  rom_addr_q <= {j_cnt + 2'd1, row};
               end
            end
            DRAIN: begin
               state     <= OUT;
               y_valid_q <= 1'b1;
               y_data_q  <= acc_sum_c;
               y_index_q <= row;
            end
            OUT: begin
               if (bus.y_ready) begin
                  y_valid_q <= 1'b0;
                  if (row == 3'd7) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state      <= ISSUE;
                     row        <= row + 3'd1;
                     j_cnt      <= '0;
                     rom_addr_q <= {2'b00, row + 3'd1};
                     acc        <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
